// File: rtl/spi_adc_slave.sv
// SPI slave front end of a 4-channel ADC: receives an 8-bit command, then returns
// a null bit and the selected Width-bit sample MSB first over a 24-period frame.
module spi_adc_slave #(
  parameter int unsigned Width = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cs_i,
  input  logic             dclk_i,
  input  logic             mosi_i,
  input  logic [Width-1:0] ch0_i,
  input  logic [Width-1:0] ch1_i,
  input  logic [Width-1:0] ch2_i,
  input  logic [Width-1:0] ch3_i,
  output logic             miso_o,
  output logic [7:0]       cmd_o,
  output logic [1:0]       ch_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int unsigned CntW = (Width > 7) ? $clog2(Width + 1) : 4;

  typedef enum logic [2:0] {IDLE, CMD, BUSY, DATA, TAIL} state_t;

  state_t           state;
  logic             cs_meta, cs_sync, cs_prev;
  logic             dclk_meta, dclk_sync, dclk_prev;
  logic             mosi_meta, mosi_sync;
  logic             rst_done, armed;
  logic [6:0]       cmd_sr;
  logic [CntW-1:0]  bit_cnt;
  logic [Width-1:0] shreg;

  logic             cs_fall, cs_rise, dclk_rise, dclk_fall;
  logic [7:0]       cmd_next;
  logic             sel_valid;
  logic [1:0]       sel_ch;
  logic [Width-1:0] sel_data;

  // Two-flop synchronizers plus one history flop for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_prev   <= 1'b1;
      dclk_meta <= 1'b0;
      dclk_sync <= 1'b0;
      dclk_prev <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      cs_meta   <= cs_i;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      dclk_meta <= dclk_i;
      dclk_sync <= dclk_meta;
      dclk_prev <= dclk_sync;
      mosi_meta <= mosi_i;
      mosi_sync <= mosi_meta;
    end
  end

  // armed blocks a cs that was already low across reset from looking like a fresh fall
  assign cs_fall   = armed & cs_prev & ~cs_sync;
  assign cs_rise   = ~cs_prev & cs_sync;
  assign dclk_rise = ~dclk_prev & dclk_sync;
  assign dclk_fall = dclk_prev & ~dclk_sync;
  assign cmd_next  = {cmd_sr, mosi_sync};

  always_comb begin
    sel_valid = 1'b1;
    sel_ch    = 2'd0;
    case (cmd_next[6:4])
      3'b001:  sel_ch = 2'd0;
      3'b101:  sel_ch = 2'd1;
      3'b010:  sel_ch = 2'd2;
      3'b110:  sel_ch = 2'd3;
      default: sel_valid = 1'b0;
    endcase
    sel_valid = sel_valid & cmd_next[7];
    case (sel_ch)
      2'd0:    sel_data = ch0_i;
      2'd1:    sel_data = ch1_i;
      2'd2:    sel_data = ch2_i;
      default: sel_data = ch3_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      rst_done <= 1'b0;
      armed    <= 1'b0;
      cmd_sr   <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      miso_o   <= 1'b0;
      cmd_o    <= 8'h00;
      ch_o     <= 2'd0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      rst_done <= 1'b1;
      if (rst_done && cs_meta && cs_sync) armed <= 1'b1;
      if (state != IDLE && cs_rise) begin
        err_o  <= 1'b1;
        miso_o <= 1'b0;
        state  <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            miso_o <= 1'b0;
            if (cs_fall) begin
              bit_cnt <= '0;
              state   <= CMD;
            end
          end
          CMD: if (dclk_rise) begin
            cmd_sr  <= cmd_next[6:0];
            bit_cnt <= bit_cnt + CntW'(1);
            if (bit_cnt == CntW'(7)) begin
              cmd_o <= cmd_next;
              if (sel_valid) begin
                ch_o  <= sel_ch;
                shreg <= sel_data;
              end else begin
                err_o <= 1'b1;
                shreg <= '0;
              end
              state <= BUSY;
            end
          end
          BUSY: if (dclk_fall) begin
            miso_o  <= 1'b0;
            bit_cnt <= '0;
            state   <= DATA;
          end
          DATA: if (dclk_fall) begin
            miso_o  <= shreg[Width-1];
            shreg   <= {shreg[Width-2:0], 1'b0};
            bit_cnt <= bit_cnt + CntW'(1);
            if (bit_cnt == CntW'(Width - 1)) begin
              bit_cnt <= '0;
              state   <= TAIL;
            end
          end
          // First TAIL rise samples the last data bit, the next three close the frame
          TAIL: begin
            if (dclk_fall) miso_o <= 1'b0;
            if (dclk_rise) begin
              bit_cnt <= bit_cnt + CntW'(1);
              if (bit_cnt == CntW'(3)) begin
                done_o <= 1'b1;
                state  <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_adc_slave.sv
// Self-checking bench for spi_adc_slave: a master model drives frames, expected
// frames go through a scoreboard queue and are compared when the frame completes.
module tb_spi_adc_slave;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b1, dclk = 1'b0, mosi = 1'b0;
  logic [11:0] ch0 = 12'h000, ch1 = 12'h000, ch2 = 12'h000, ch3 = 12'h000;
  logic        miso, done, err;
  logic [7:0]  cmd;
  logic [1:0]  ch;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  logic [1:0] ch_m = 2'd0;

  typedef struct {
    logic [23:0] bits;
    int          nrise;
    logic [7:0]  cmd;
    logic [1:0]  ch;
    int          done_n;
    int          err_n;
  } exp_t;
  exp_t sb[$];

  spi_adc_slave #(.Width(12)) dut (
    .clk_i(clk), .rst_i(rst), .cs_i(cs), .dclk_i(dclk), .mosi_i(mosi),
    .ch0_i(ch0), .ch1_i(ch1), .ch2_i(ch2), .ch3_i(ch3),
    .miso_o(miso), .cmd_o(cmd), .ch_o(ch), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  // Counts high cycles, so a stretched pulse shows up as an extra event
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err)  err_cnt  <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master: cs low, then nrise dclk periods; miso sampled just before each rise
  task automatic drive(input logic [7:0] c, input int nrise, input logic chg,
                       input logic [11:0] chg_val, output logic [23:0] got);
    got = '0;
    cs = 1'b0;
    clocks(HALF);
    for (int i = 0; i < nrise; i++) begin
      mosi = (i < 8) ? c[7-i] : 1'b0;
      clocks(HALF);
      got[23-i] = miso;
      dclk = 1'b1;
      clocks(HALF);
      dclk = 1'b0;
      if (chg && i == 7) ch0 = chg_val;
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] c, input int nrise,
                       input logic chg, input logic [11:0] chg_val);
    exp_t e, p;
    logic [23:0] got;
    logic [11:0] sample;
    logic        valid;
    int          d0, e0, sh;
    valid = 1'b1;
    case (c[6:4])
      3'b001:  begin sample = ch0; e.ch = 2'd0; end
      3'b101:  begin sample = ch1; e.ch = 2'd1; end
      3'b010:  begin sample = ch2; e.ch = 2'd2; end
      3'b110:  begin sample = ch3; e.ch = 2'd3; end
      default: begin sample = 12'h000; e.ch = ch_m; valid = 1'b0; end
    endcase
    if (!c[7]) valid = 1'b0;
    if (valid) ch_m = e.ch;
    e.ch     = ch_m;
    e.bits   = valid ? {9'b0, sample, 3'b000} : 24'h0;
    e.nrise  = nrise;
    e.cmd    = c;
    e.done_n = (nrise == 24) ? 1 : 0;
    e.err_n  = (valid ? 0 : 1) + ((nrise < 24) ? 1 : 0);
    sb.push_back(e);

    d0 = done_cnt;
    e0 = err_cnt;
    drive(c, nrise, chg, chg_val, got);
    clocks(HALF);
    cs = 1'b1;
    clocks(HALF);

    p  = sb.pop_front();
    sh = 24 - p.nrise;
    check({tag, " miso"}, 32'(got >> sh), 32'(p.bits >> sh));
    check({tag, " cmd"},  32'(cmd), 32'(p.cmd));
    check({tag, " ch"},   32'(ch), 32'(p.ch));
    check({tag, " done"}, 32'(done_cnt - d0), 32'(p.done_n));
    check({tag, " err"},  32'(err_cnt - e0), 32'(p.err_n));
  endtask

  initial begin
    logic [23:0] junk;
    int d0, e0;
    clocks(3);
    check("rst miso", 32'(miso), 32'd0);
    check("rst cmd",  32'(cmd),  32'h00);
    check("rst ch",   32'(ch),   32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err",  32'(err),  32'd0);
    rst = 1'b0;
    clocks(5);

    // dclk/mosi activity with cs high is ignored
    d0 = done_cnt; e0 = err_cnt;
    for (int i = 0; i < 10; i++) begin
      mosi = 1'b1; dclk = 1'b1; clocks(HALF); dclk = 1'b0; clocks(HALF);
    end
    check("idle cmd",    32'(cmd), 32'h00);
    check("idle pulses", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);

    ch0 = 12'hA5C; ch1 = 12'hFFF; ch2 = 12'h001; ch3 = 12'h800;
    frame("ch0",     8'h97, 24, 1'b0, 12'h000);
    frame("ch1",     8'hD7, 24, 1'b0, 12'h000);
    frame("ch2",     8'hA7, 24, 1'b0, 12'h000);
    frame("ch3",     8'hE7, 24, 1'b0, 12'h000);
    frame("nostart", 8'h17, 24, 1'b0, 12'h000);
    frame("badaddr", 8'hB7, 24, 1'b0, 12'h000);
    frame("abort",   8'h97, 14, 1'b0, 12'h000);
    frame("after",   8'h97, 24, 1'b0, 12'h000);
    ch0 = 12'h123;
    frame("latch",   8'h97, 24, 1'b1, 12'h456);

    // Reset in the middle of the data phase
    d0 = done_cnt; e0 = err_cnt;
    drive(8'h97, 12, 1'b0, 12'h000, junk);
    clocks(2);
    rst = 1'b1;
    @(negedge clk);
    check("mrst miso", 32'(miso), 32'd0);
    check("mrst cmd",  32'(cmd),  32'h00);
    check("mrst ch",   32'(ch),   32'd0);
    clocks(3);
    rst = 1'b0;
    ch_m = 2'd0;
    for (int i = 0; i < 4; i++) begin
      dclk = 1'b1; clocks(HALF); dclk = 1'b0; clocks(HALF);
    end
    cs = 1'b1;
    clocks(HALF);
    check("mrst pulses", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
    check("mrst hold",   32'(cmd), 32'h00);
    frame("postrst", 8'h97, 24, 1'b0, 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
